// File: rtl/fd_m_monitor.sv
// fd_m_monitor: receive-side checker for the divide-by-M DIV_M pulse train (period, width, timeout, lock)
//   clk_ext     in   divider clock, all logic on posedge
//   rst         in   async active-high reset
//   en          in   monitor enable, 0 forces IDLE
//   M           in   programmed divide value, latched on IDLE->ACQ
//   DIV_M       in   active-low divided pulse
//   locked      out  period stable for LOCK_CNT consecutive periods
//   err         out  1-cycle pulse on period/width/timeout error
//   cfg_err     out  expected period < 2 while not IDLE
//   period_meas out  last falling-edge-to-falling-edge interval
//   err_cnt     out  saturating count of err pulses
module fd_m_monitor #(
    parameter int MW       = 2,
    parameter int CNT_W    = 8,
    parameter int PER_OFS  = 1,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk_ext,
    input  logic             rst,
    input  logic             en,
    input  logic [MW-1:0]    M,
    input  logic             DIV_M,
    output logic             locked,
    output logic             err,
    output logic             cfg_err,
    output logic [CNT_W-1:0] period_meas,
    output logic [ERR_W-1:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} state_t;
    state_t state_q, state_d;
    logic             div_q, locked_q, locked_d, err_q, err_d, cfg_q, cfg_d, pe_q, pe_d;
    logic [CNT_W-1:0] ivl_q, ivl_d, exp_q, exp_d, per_q, per_d;
    logic [1:0]       low_q, low_d;
    logic [3:0]       match_q, match_d, match_inc;
    logic [ERR_W-1:0] ecnt_q, ecnt_d;
    logic [CNT_W-1:0] exp_new, ivl_inc, tmo_lim;
    logic [CNT_W:0]   dbl;
    logic             fall, eq, wid;

    assign exp_new   = CNT_W'(M) + CNT_W'(PER_OFS);
    assign dbl       = {exp_q, 1'b0};
    assign tmo_lim   = dbl[CNT_W] ? '1 : dbl[CNT_W-1:0];
    assign fall      = div_q & ~DIV_M;
    assign eq        = ivl_q == exp_q;
    assign ivl_inc   = &ivl_q ? ivl_q : ivl_q + 1'b1;
    assign match_inc = match_q + 4'd1;
    assign low_d     = DIV_M ? 2'd0 : (&low_q ? low_q : low_q + 2'd1);
    // second consecutive low cycle; suppressed if this pulse already flagged a period error
    assign wid       = ~DIV_M & (low_q == 2'd1) & ~pe_q;

    always_comb begin
        state_d  = state_q;
        ivl_d    = ivl_q;
        exp_d    = exp_q;
        per_d    = per_q;
        match_d  = match_q;
        locked_d = locked_q;
        pe_d     = pe_q;
        err_d    = 1'b0;
        if (!en) begin
            state_d  = IDLE;
            ivl_d    = '0;
            match_d  = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQ;
                    exp_d   = exp_new;
                end
                ACQ: begin
                    if (exp_q >= CNT_W'(2) && fall) begin
                        state_d = TRACK;
                        ivl_d   = CNT_W'(1);
                        match_d = '0;
                        pe_d    = 1'b0;
                    end
                end
                default: begin
                    ivl_d = ivl_inc;
                    // fall has priority over a coincident timeout
                    if (fall) begin
                        per_d = ivl_q;
                        ivl_d = CNT_W'(1);
                        pe_d  = ~eq;
                        if (eq) begin
                            match_d = (match_q == 4'(LOCK_CNT)) ? match_q : match_inc;
                            if (match_d == 4'(LOCK_CNT)) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            err_d    = 1'b1;
                            match_d  = '0;
                            locked_d = 1'b0;
                            state_d  = TRACK;
                        end
                    end else if (ivl_q >= tmo_lim) begin
                        err_d    = 1'b1;
                        match_d  = '0;
                        locked_d = 1'b0;
                        ivl_d    = '0;
                        state_d  = ACQ;
                    end else if (wid) begin
                        err_d    = 1'b1;
                        match_d  = '0;
                        locked_d = 1'b0;
                        state_d  = TRACK;
                    end
                end
            endcase
        end
        cfg_d  = (state_d != IDLE) && (exp_d < CNT_W'(2));
        ecnt_d = (err_d && !(&ecnt_q)) ? ecnt_q + 1'b1 : ecnt_q;
    end

    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= 1'b1;
            ivl_q    <= '0;
            exp_q    <= '0;
            per_q    <= '0;
            low_q    <= '0;
            match_q  <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cfg_q    <= 1'b0;
            pe_q     <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= DIV_M;
            ivl_q    <= ivl_d;
            exp_q    <= exp_d;
            per_q    <= per_d;
            low_q    <= low_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            cfg_q    <= cfg_d;
            pe_q     <= pe_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign locked      = locked_q;
    assign err         = err_q;
    assign cfg_err     = cfg_q;
    assign period_meas = per_q;
    assign err_cnt     = ecnt_q;
endmodule

// File: tb/tb_fd_m_monitor.sv
// tb_fd_m_monitor: directed and random pulse trains checked against an event-level model of the monitor
module tb_fd_m_monitor;
    logic       clk_ext = 1'b0;
    logic       rst, en, DIV_M;
    logic [1:0] M;
    logic       locked, err, cfg_err;
    logic [7:0] period_meas, err_cnt;

    fd_m_monitor dut (
        .clk_ext(clk_ext), .rst(rst), .en(en), .M(M), .DIV_M(DIV_M),
        .locked(locked), .err(err), .cfg_err(cfg_err),
        .period_meas(period_meas), .err_cnt(err_cnt)
    );

    always #5 clk_ext = ~clk_ext;

    int checks = 0, failures = 0;
    // model: phase 0 idle, 1 acquiring, 2 tracking, 3 locked; times are step indices
    int ph, mexp, good, mlocked, mcfg, merr, mper, mecnt, mc, last_fall, low_start, prev_d, perr;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        assert (act === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp_v);
        end
    endtask

    task automatic check_all();
        chk("locked", {31'b0, locked}, mlocked);
        chk("err", {31'b0, err}, merr);
        chk("cfg_err", {31'b0, cfg_err}, mcfg);
        chk("period_meas", {24'b0, period_meas}, mper);
        chk("err_cnt", {24'b0, err_cnt}, mecnt);
    endtask

    task automatic model_reset();
        ph = 0; mexp = 0; good = 0; mlocked = 0; mcfg = 0; merr = 0; mper = 0; mecnt = 0;
        mc = 0; last_fall = 0; low_start = 0; prev_d = 1; perr = 0;
    endtask

    task automatic model_step(input logic e, input logic d);
        int ivl;
        bit fall, wid;
        mc++;
        fall = (prev_d == 1) && !d;
        if (fall) low_start = mc;
        wid = !d && (mc - low_start + 1 == 2) && !perr;
        merr = 0;
        if (!e) begin
            ph = 0; good = 0; mlocked = 0; mcfg = 0;
        end else if (ph == 0) begin
            ph = 1; mexp = int'(M) + 1; mcfg = (mexp < 2);
        end else if (ph == 1) begin
            if (!mcfg && fall) begin
                ph = 2; last_fall = mc; good = 0; perr = 0;
            end
        end else begin
            ivl = mc - last_fall;
            if (fall) begin
                mper = ivl; last_fall = mc; perr = (ivl != mexp);
                if (ivl == mexp) begin
                    good++;
                    if (good >= 4) begin ph = 3; mlocked = 1; end
                end else begin
                    good = 0; mlocked = 0; ph = 2; merr = 1;
                end
            end else if (ivl >= 2 * mexp) begin
                merr = 1; good = 0; mlocked = 0; ph = 1;
            end else if (wid) begin
                merr = 1; good = 0; mlocked = 0; ph = 2;
            end
        end
        if (merr && mecnt < 255) mecnt++;
        prev_d = d;
    endtask

    task automatic drv(input logic e, input logic d);
        @(negedge clk_ext);
        check_all();
        en = e;
        DIV_M = d;
        model_step(e, d);
    endtask

    task automatic pulse(input int len, input int w);
        for (int i = 0; i < len; i++) drv(1'b1, (i >= w) ? 1'b1 : 1'b0);
    endtask

    task automatic do_rst();
        @(negedge clk_ext);
        rst = 1'b1; en = 1'b0; DIV_M = 1'b1;
        #1;
        chk("rst_locked", {31'b0, locked}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_cfg_err", {31'b0, cfg_err}, 0);
        chk("rst_period_meas", {24'b0, period_meas}, 0);
        chk("rst_err_cnt", {24'b0, err_cnt}, 0);
        model_reset();
        @(negedge clk_ext);
        rst = 1'b0;
    endtask

    initial begin
        int e, sel, len, w;
        rst = 1'b1; en = 1'b0; DIV_M = 1'b1; M = 2'd0;
        model_reset();
        // 1: lock at M=2
        do_rst();
        M = 2'd2;
        drv(1, 1); drv(1, 1);
        for (int k = 0; k < 4; k++) pulse(3, 1);
        chk("t1_not_yet_locked", {31'b0, locked}, 0);
        pulse(3, 1);
        chk("t1_locked", {31'b0, locked}, 1);
        chk("t1_period", {24'b0, period_meas}, 3);
        chk("t1_err_cnt", {24'b0, err_cnt}, 0);
        // 2: one stretched period, then relock
        pulse(4, 1); pulse(3, 1);
        chk("t2_unlocked", {31'b0, locked}, 0);
        chk("t2_err_cnt", {24'b0, err_cnt}, 1);
        chk("t2_period", {24'b0, period_meas}, 4);
        for (int k = 0; k < 4; k++) pulse(3, 1);
        chk("t2_relocked", {31'b0, locked}, 1);
        // 3: width error at M=3
        do_rst();
        M = 2'd3;
        drv(1, 1); drv(1, 1);
        for (int k = 0; k < 5; k++) pulse(4, 1);
        chk("t3_locked", {31'b0, locked}, 1);
        pulse(4, 2);
        chk("t3_unlocked", {31'b0, locked}, 0);
        chk("t3_err_cnt", {24'b0, err_cnt}, 1);
        // 4: DIV_M stuck high -> timeout, then reacquire
        do_rst();
        M = 2'd2;
        drv(1, 1); drv(1, 1);
        for (int k = 0; k < 5; k++) pulse(3, 1);
        pulse(12, 1);
        chk("t4_unlocked", {31'b0, locked}, 0);
        chk("t4_err_cnt", {24'b0, err_cnt}, 1);
        for (int k = 0; k < 5; k++) pulse(3, 1);
        chk("t4_relocked", {31'b0, locked}, 1);
        // 5: cfg error at M=0, then M=1
        do_rst();
        M = 2'd0;
        drv(1, 1); drv(1, 1);
        for (int k = 0; k < 6; k++) pulse(2, 1);
        chk("t5_cfg_err", {31'b0, cfg_err}, 1);
        chk("t5_no_lock", {31'b0, locked}, 0);
        drv(0, 1); drv(0, 1);
        M = 2'd1;
        drv(1, 1); drv(1, 1);
        for (int k = 0; k < 6; k++) pulse(2, 1);
        chk("t5_cfg_clear", {31'b0, cfg_err}, 0);
        chk("t5_period", {24'b0, period_meas}, 2);
        chk("t5_locked", {31'b0, locked}, 1);
        // 6: M change while locked is ignored; reset mid-period
        do_rst();
        M = 2'd2;
        drv(1, 1); drv(1, 1);
        for (int k = 0; k < 5; k++) pulse(3, 1);
        M = 2'd3;
        for (int k = 0; k < 3; k++) pulse(3, 1);
        chk("t6_still_locked", {31'b0, locked}, 1);
        drv(1, 0);
        do_rst();
        // random pulse trains against the model
        for (int r = 0; r < 8; r++) begin
            M = 2'($urandom_range(2, 3));
            drv(1, 1); drv(1, 1);
            e = int'(M) + 1;
            for (int k = 0; k < 25; k++) begin
                sel = $urandom_range(0, 9);
                len = (sel < 6) ? e : (sel < 8) ? e - 1 : (sel == 8) ? e + 1 : 2 * e + 2;
                w = ($urandom_range(0, 4) == 0 && len >= 3) ? 2 : 1;
                pulse(len, w);
            end
            drv(0, 1); drv(0, 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
